hist_eq_frame_ctrl: RTL and testbench

- Frame-level sequencer for the histogram-equalisation pipeline.
- Observes the 8-bit AXI4-Stream video input (tvalid/tlast/tuser) and gates it with s_tready.
- Per frame, sequences the histogram RAM through four phases: clear, accumulate, CDF sweep, LUT swap.
- Detects and recovers from dropped/misplaced tuser and tlast so the datapath stays frame-aligned.

---
 rtl/hist_eq_pkg.sv | 21 ++
 rtl/hist_eq_frame_ctrl_pos_counter.sv | 51 +++++
 rtl/hist_eq_frame_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hist_eq_frame_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalisation frame sequencer.
package hist_eq_pkg;

  localparam int unsigned PIX_BITS = 8;
  localparam int unsigned NBINS    = 2**PIX_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    WAIT_SOF = 3'd2,
    ACCUM    = 3'd3,
    CDF      = 3'd4,
    SWAP     = 3'd5
  } state_t;

  // States in which the input stream is accepted.
  function automatic logic is_stream(input state_t s);
    return (s == WAIT_SOF) || (s == ACCUM);
  endfunction

endpackage

// File: rtl/hist_eq_frame_ctrl_pos_counter.sv
// Pixel/line position tracker; line ends are count-driven, with tlast allowed to cut a line short.
module video_pos_counter #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned HEIGHT = 10,
  localparam int unsigned PW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int unsigned LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_beat,
  input  logic          i_tlast,
  output logic [PW-1:0] o_pix_cnt,
  output logic [LW-1:0] o_line_cnt,
  output logic          o_line_end_c,
  output logic          o_frame_end_c,
  output logic          o_early_tlast_c,
  output logic          o_missing_tlast_c
);

  logic [PW-1:0] r_pix_cnt;
  logic [LW-1:0] r_line_cnt;
  logic          w_last_pix;
  logic          w_last_line;

  assign w_last_pix  = (r_pix_cnt  == PW'(WIDTH - 1));
  assign w_last_line = (r_line_cnt == LW'(HEIGHT - 1));

  assign o_pix_cnt         = r_pix_cnt;
  assign o_line_cnt        = r_line_cnt;
  assign o_line_end_c      = i_beat & (w_last_pix | i_tlast);
  assign o_frame_end_c     = o_line_end_c & w_last_line;
  assign o_early_tlast_c   = i_beat & i_tlast & ~w_last_pix;
  assign o_missing_tlast_c = i_beat & w_last_pix & ~i_tlast;

  // Advance position on every accepted pixel; wrap line/frame at their ends.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (i_beat) begin
      if (o_line_end_c) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= o_frame_end_c ? '0 : r_line_cnt + LW'(1);
      end else begin
        r_pix_cnt <= r_pix_cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/hist_eq_frame_ctrl.sv
// Frame sequencer: clear histogram, accumulate one frame, sweep CDF, swap LUT; keeps the stream frame-aligned.
module hist_eq_frame_ctrl
  import hist_eq_pkg::*;
#(
  parameter int unsigned N      = PIX_BITS,
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned HEIGHT = 10
) (
  input  logic         sys_clk,
  input  logic         sys_reset,
  input  logic         en,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  input  logic         s_tuser,
  output logic         s_tready,
  output logic         hist_acc_en,
  output logic         hist_clr_en,
  output logic         cdf_rd_en,
  output logic [N-1:0] hist_addr,
  output logic         lut_swap,
  output logic [15:0]  frame_cnt,
  output logic         err_early_tlast,
  output logic         err_missing_tlast,
  output logic         err_early_sof
);

  localparam int unsigned PW       = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned LW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned NUM_BINS = 2**N;
  localparam logic [N-1:0] LAST_BIN = N'(NUM_BINS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_addr;
  logic [N-1:0]  w_addr_nxt;
  logic [15:0]   r_frame_cnt;
  logic [15:0]   w_frame_cnt_nxt;
  logic          r_err_early_tlast;
  logic          r_err_missing_tlast;
  logic          r_err_early_sof;
  logic          w_err_early_tlast_nxt;
  logic          w_err_missing_tlast_nxt;
  logic          w_err_early_sof_nxt;
  logic          r_tready;
  logic          r_clr_en;
  logic          r_cdf_en;
  logic          r_swap;

  logic          w_beat;
  logic          w_sof_mid;
  logic          w_early_sof;
  logic          w_pix_beat;
  logic          w_cnt_clr;
  logic [PW-1:0] w_pix_cnt;
  logic [LW-1:0] w_line_cnt;
  logic          w_line_end_c;
  logic          w_frame_end_c;
  logic          w_early_tlast_c;
  logic          w_missing_tlast_c;

  // Stream qualification: a tuser away from (0,0) abandons the frame instead of being counted.
  assign w_beat      = s_tvalid & r_tready;
  assign w_sof_mid   = s_tuser & ((w_pix_cnt != '0) | (w_line_cnt != '0));
  assign w_early_sof = w_beat & (r_state == ACCUM) & w_sof_mid;
  assign w_pix_beat  = w_beat & (((r_state == WAIT_SOF) & s_tuser) |
                                 ((r_state == ACCUM) & ~w_sof_mid));
  assign w_cnt_clr   = w_early_sof | ~r_tready;

  video_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .i_clk             (sys_clk),
    .i_rst             (sys_reset),
    .i_clr             (w_cnt_clr),
    .i_beat            (w_pix_beat),
    .i_tlast           (s_tlast),
    .o_pix_cnt         (w_pix_cnt),
    .o_line_cnt        (w_line_cnt),
    .o_line_end_c      (w_line_end_c),
    .o_frame_end_c     (w_frame_end_c),
    .o_early_tlast_c   (w_early_tlast_c),
    .o_missing_tlast_c (w_missing_tlast_c)
  );

  // Next-state, bin sweep, frame count and sticky error logic.
  always_comb begin
    w_state_nxt             = r_state;
    w_addr_nxt              = r_addr;
    w_frame_cnt_nxt         = r_frame_cnt;
    w_err_early_tlast_nxt   = r_err_early_tlast;
    w_err_missing_tlast_nxt = r_err_missing_tlast;
    w_err_early_sof_nxt     = r_err_early_sof;

    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = CLEAR;
          w_addr_nxt  = '0;
        end
      end
      CLEAR: begin
        if (r_addr == LAST_BIN) begin
          w_state_nxt = WAIT_SOF;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = r_addr + N'(1);
        end
      end
      WAIT_SOF: begin
        if (w_pix_beat) begin
          w_state_nxt = w_frame_end_c ? CDF : ACCUM;
        end
      end
      ACCUM: begin
        if (w_early_sof) begin
          w_state_nxt         = CLEAR;
          w_addr_nxt          = '0;
          w_err_early_sof_nxt = 1'b1;
        end else if (w_frame_end_c) begin
          w_state_nxt = CDF;
          w_addr_nxt  = '0;
        end
      end
      CDF: begin
        if (r_addr == LAST_BIN) begin
          w_state_nxt = SWAP;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = r_addr + N'(1);
        end
      end
      SWAP: begin
        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
        w_addr_nxt      = '0;
        w_state_nxt     = en ? CLEAR : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_addr_nxt  = '0;
      end
    endcase

    // Line framing errors resolve on the beat that closes the line.
    if (w_line_end_c) begin
      w_err_early_tlast_nxt   = w_err_early_tlast_nxt   | w_early_tlast_c;
      w_err_missing_tlast_nxt = w_err_missing_tlast_nxt | w_missing_tlast_c;
    end
  end

  // State, sweep address, counters, flags and phase-decoded outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state             <= IDLE;
      r_addr              <= '0;
      r_frame_cnt         <= '0;
      r_err_early_tlast   <= 1'b0;
      r_err_missing_tlast <= 1'b0;
      r_err_early_sof     <= 1'b0;
      r_tready            <= 1'b0;
      r_clr_en            <= 1'b0;
      r_cdf_en            <= 1'b0;
      r_swap              <= 1'b0;
    end else begin
      r_state             <= w_state_nxt;
      r_addr              <= w_addr_nxt;
      r_frame_cnt         <= w_frame_cnt_nxt;
      r_err_early_tlast   <= w_err_early_tlast_nxt;
      r_err_missing_tlast <= w_err_missing_tlast_nxt;
      r_err_early_sof     <= w_err_early_sof_nxt;
      r_tready            <= is_stream(w_state_nxt);
      r_clr_en            <= (w_state_nxt == CLEAR);
      r_cdf_en            <= (w_state_nxt == CDF);
      r_swap              <= (w_state_nxt == SWAP);
    end
  end

  assign s_tready          = r_tready;
  assign hist_acc_en       = w_pix_beat;
  assign hist_clr_en       = r_clr_en;
  assign cdf_rd_en         = r_cdf_en;
  assign hist_addr         = r_addr;
  assign lut_swap          = r_swap;
  assign frame_cnt         = r_frame_cnt;
  assign err_early_tlast   = r_err_early_tlast;
  assign err_missing_tlast = r_err_missing_tlast;
  assign err_early_sof     = r_err_early_sof;

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Randomized bench for hist_eq_frame_ctrl against a frame-level behavioural model.
module tb_hist_eq_frame_ctrl;

  localparam int W     = 10;
  localparam int H     = 10;
  localparam int BINS  = 256;

  logic        sys_clk;
  logic        sys_reset;
  logic        en;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic        s_tready;
  logic        hist_acc_en;
  logic        hist_clr_en;
  logic        cdf_rd_en;
  logic [7:0]  hist_addr;
  logic        lut_swap;
  logic [15:0] frame_cnt;
  logic        err_early_tlast;
  logic        err_missing_tlast;
  logic        err_early_sof;

  hist_eq_frame_ctrl #(.N(8), .WIDTH(W), .HEIGHT(H)) dut (
    .sys_clk           (sys_clk),
    .sys_reset         (sys_reset),
    .en                (en),
    .s_tvalid          (s_tvalid),
    .s_tlast           (s_tlast),
    .s_tuser           (s_tuser),
    .s_tready          (s_tready),
    .hist_acc_en       (hist_acc_en),
    .hist_clr_en       (hist_clr_en),
    .cdf_rd_en         (cdf_rd_en),
    .hist_addr         (hist_addr),
    .lut_swap          (lut_swap),
    .frame_cnt         (frame_cnt),
    .err_early_tlast   (err_early_tlast),
    .err_missing_tlast (err_missing_tlast),
    .err_early_sof     (err_early_sof)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Scoreboard counters
  int n_vec;
  int n_miscmp;
  int n_acc, n_clr, n_cdf, n_swap;

  // Stream token queue
  typedef struct packed { logic u; logic l; } tok_t;
  tok_t q[$];
  bit   always_valid;
  bit   m_beat;

  // Behavioural model: phase of the frame, sweep index, pixel position, frame count, sticky errors
  typedef enum int {P_IDLE, P_CL, P_WS, P_AC, P_CD, P_SW} ph_t;
  ph_t m_ph;
  int  m_addr, m_x, m_y, m_fc;
  bit  m_ee, m_em, m_es;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = P_IDLE; m_addr = 0; m_x = 0; m_y = 0; m_fc = 0;
    m_ee = 0; m_em = 0; m_es = 0;
  endfunction

  // Accept one pixel at (m_x, m_y); returns 1 when it closes the last line.
  function automatic bit model_pixel(input bit tl);
    bit done = 0;
    if (m_x == W-1 || tl) begin
      if (m_x == W-1 && !tl) m_em = 1;
      if (m_x <  W-1)        m_ee = 1;
      m_x = 0;
      if (m_y == H-1) begin m_y = 0; done = 1; end
      else m_y++;
    end else begin
      m_x++;
    end
    return done;
  endfunction

  function automatic void model_step(input bit beat);
    case (m_ph)
      P_IDLE: if (en) begin m_ph = P_CL; m_addr = 0; end
      P_CL:   if (m_addr == BINS-1) begin m_ph = P_WS; m_addr = 0; end else m_addr++;
      P_WS:   if (beat && s_tuser) m_ph = model_pixel(s_tlast) ? P_CD : P_AC;
      P_AC: begin
        if (beat) begin
          if (s_tuser && (m_x != 0 || m_y != 0)) begin
            m_es = 1; m_ph = P_CL; m_addr = 0; m_x = 0; m_y = 0;
          end else if (model_pixel(s_tlast)) begin
            m_ph = P_CD; m_addr = 0;
          end
        end
      end
      P_CD:   if (m_addr == BINS-1) begin m_ph = P_SW; m_addr = 0; end else m_addr++;
      P_SW: begin
        m_fc = (m_fc + 1) % 65536;
        m_ph = en ? P_CL : P_IDLE;
      end
      default: m_ph = P_IDLE;
    endcase
  endfunction

  // Compare one cycle of DUT outputs against the model, then advance both.
  task automatic tick();
    bit e_tr, e_acc;
    @(negedge sys_clk);
    e_tr  = (m_ph == P_WS) || (m_ph == P_AC);
    e_acc = 0;
    if (s_tvalid && e_tr) begin
      if (m_ph == P_WS) e_acc = s_tuser;
      else              e_acc = !(s_tuser && (m_x != 0 || m_y != 0));
    end
    check_val("ctl", 32'({s_tready, hist_acc_en, hist_clr_en, cdf_rd_en, lut_swap}),
              32'({e_tr, e_acc, m_ph == P_CL, m_ph == P_CD, m_ph == P_SW}));
    check_val("hist_addr", 32'(hist_addr), 32'(m_addr));
    check_val("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check_val("err_flags", 32'({err_early_tlast, err_missing_tlast, err_early_sof}),
              32'({m_ee, m_em, m_es}));
    n_acc  += int'(hist_acc_en);
    n_clr  += int'(hist_clr_en);
    n_cdf  += int'(cdf_rd_en);
    n_swap += int'(lut_swap);
    m_beat = s_tvalid && e_tr;
    if (sys_reset) model_reset();
    else           model_step(m_beat);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive();
    if (q.size() > 0 && (always_valid || $urandom_range(3) != 0)) begin
      s_tvalid = 1'b1; s_tuser = q[0].u; s_tlast = q[0].l;
    end else begin
      s_tvalid = 1'b0;
      s_tuser  = 1'($urandom_range(1));
      s_tlast  = 1'($urandom_range(1));
    end
  endtask

  task automatic cycle();
    drive();
    tick();
    if (m_beat) void'(q.pop_front());
  endtask

  task automatic clear_counts();
    n_acc = 0; n_clr = 0; n_cdf = 0; n_swap = 0;
  endtask

  task automatic do_reset();
    q.delete();
    sys_reset = 1'b1; en = 1'b0;
    cycle();
    sys_reset = 1'b0;
    clear_counts();
  endtask

  // Queue one frame: junk beats, then pixels; el/ep = early tlast, ml = dropped tlast line, sl/sp = stray tuser.
  task automatic push_frame(input int junk, input int el, input int ep, input int ml,
                            input int sl, input int sp);
    tok_t t;
    for (int j = 0; j < junk; j++) begin
      t.u = 1'b0; t.l = 1'($urandom_range(1)); q.push_back(t);
    end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == sl && x == sp) begin
          t.u = 1'b1; t.l = 1'($urandom_range(1)); q.push_back(t);
          return;
        end
        t.u = (x == 0 && y == 0);
        t.l = ((x == W-1) && (y != ml)) || (y == el && x == ep);
        q.push_back(t);
        if (y == el && x == ep) break;
      end
    end
  endtask

  task automatic run_frames(input int budget, input bit rnd_en);
    bit done = 0;
    en = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      if (rnd_en) en = (q.size() > 0) ? 1'($urandom_range(1)) : 1'b0;
      cycle();
      if (!rnd_en) en = 1'b0;
      if (m_ph == P_IDLE && q.size() == 0) done = 1;
    end
    check_val("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    bit hit;
    n_vec = 0; n_miscmp = 0;
    clear_counts();
    sys_reset = 1'b1; en = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    always_valid = 1'b0;
    model_reset();
    @(posedge sys_clk); #1;

    // Nominal frame, stream always valid
    do_reset();
    always_valid = 1'b1;
    push_frame(0, -1, -1, -1, -1, -1);
    run_frames(2000, 1'b0);
    check_val("nom_clr",  32'(n_clr),  32'd256);
    check_val("nom_acc",  32'(n_acc),  32'd100);
    check_val("nom_cdf",  32'(n_cdf),  32'd256);
    check_val("nom_swap", 32'(n_swap), 32'd1);
    check_val("nom_fc",   32'(frame_cnt), 32'd1);
    check_val("nom_err",  32'({err_early_tlast, err_missing_tlast, err_early_sof}), 32'd0);
    always_valid = 1'b0;

    // Junk beats ahead of the start of frame
    do_reset();
    push_frame(3, -1, -1, -1, -1, -1);
    run_frames(3000, 1'b0);
    check_val("junk_acc", 32'(n_acc), 32'd100);
    check_val("junk_fc",  32'(frame_cnt), 32'd1);

    // tlast dropped on line 0
    do_reset();
    push_frame(0, -1, -1, 0, -1, -1);
    run_frames(3000, 1'b0);
    check_val("miss_acc", 32'(n_acc), 32'd100);
    check_val("miss_err", 32'({err_early_tlast, err_missing_tlast, err_early_sof}), 32'b010);
    check_val("miss_fc",  32'(frame_cnt), 32'd1);

    // tlast injected at line 0 pixel 7
    do_reset();
    push_frame(0, 0, 7, -1, -1, -1);
    run_frames(3000, 1'b0);
    check_val("early_acc", 32'(n_acc), 32'd98);
    check_val("early_err", 32'({err_early_tlast, err_missing_tlast, err_early_sof}), 32'b100);
    check_val("early_cdf", 32'(n_cdf), 32'd256);

    // Stray tuser at line 3 pixel 2, then a clean frame
    do_reset();
    push_frame(0, -1, -1, -1, 3, 2);
    push_frame(2, -1, -1, -1, -1, -1);
    run_frames(4000, 1'b0);
    check_val("sof_acc",  32'(n_acc),  32'd132);
    check_val("sof_clr",  32'(n_clr),  32'd512);
    check_val("sof_swap", 32'(n_swap), 32'd1);
    check_val("sof_err",  32'({err_early_tlast, err_missing_tlast, err_early_sof}), 32'b001);
    check_val("sof_fc",   32'(frame_cnt), 32'd1);

    // Reset in the middle of the second frame's CDF sweep
    do_reset();
    push_frame(0, -1, -1, 0, -1, -1);
    push_frame(0, -1, -1, -1, -1, -1);
    en = 1'b1;
    hit = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      cycle();
      if (m_ph == P_CD && m_addr == 100 && m_fc == 1) hit = 1;
    end
    check_val("cdf_reached", 32'(hit), 32'd1);
    check_val("pre_rst_addr", 32'(hist_addr), 32'd100);
    sys_reset = 1'b1; en = 1'b0;
    cycle();
    sys_reset = 1'b0;
    check_val("rst_outs", {s_tready, hist_acc_en, hist_clr_en, cdf_rd_en, lut_swap,
                           hist_addr, frame_cnt, err_early_tlast, err_missing_tlast,
                           err_early_sof}, 32'd0);
    q.delete();
    clear_counts();
    push_frame(1, -1, -1, -1, -1, -1);
    run_frames(3000, 1'b0);
    check_val("rst_clr",  32'(n_clr),  32'd256);
    check_val("rst_swap", 32'(n_swap), 32'd1);
    check_val("rst_fc",   32'(frame_cnt), 32'd1);

    // Randomized frames with random faults, random en and random valid gaps
    do_reset();
    for (int f = 0; f < 6; f++) begin
      int el, ep, ml, sl, sp;
      el = ($urandom_range(2) == 0) ? int'($urandom_range(H-1)) : -1;
      ep = int'($urandom_range(W-2));
      ml = ($urandom_range(2) == 0) ? int'($urandom_range(H-1)) : -1;
      sl = ($urandom_range(2) == 0) ? int'($urandom_range(H-1, 1)) : -1;
      sp = int'($urandom_range(W-1));
      push_frame(int'($urandom_range(3)), el, ep, ml, sl, sp);
    end
    push_frame(int'($urandom_range(3)), -1, -1, -1, -1, -1);
    run_frames(15000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
